// File: rtl/edid_store.sv
// EDID sink RAM with an auto-incrementing segment/offset DDC read port and a
// background block-checksum engine that borrows the read port when it is idle.
module edid_store #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned OFF_W       = 8,
    parameter int unsigned BLOCK_BYTES = 128
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   we,
    input  logic [ADDR_W-1:0]                      waddr,
    input  logic [DATA_W-1:0]                      wdata,
    input  logic                                   seg_load,
    input  logic [ADDR_W-OFF_W-1:0]                seg,
    input  logic                                   off_load,
    input  logic [OFF_W-1:0]                       off,
    input  logic                                   rd_req,
    output logic [DATA_W-1:0]                      rdata,
    output logic                                   rvalid,
    input  logic                                   chk_start,
    input  logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]  chk_block,
    output logic                                   chk_busy,
    output logic                                   chk_done,
    output logic [DATA_W-1:0]                      chk_sum,
    output logic                                   chk_ok
);

    localparam int unsigned SEG_W = ADDR_W - OFF_W;
    localparam int unsigned CNT_W = $clog2(BLOCK_BYTES);
    localparam int unsigned BLK_W = ADDR_W - CNT_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} chk_state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [SEG_W-1:0]  seg_q, seg_eff;
    logic [OFF_W-1:0]  off_q, off_eff, off_d;
    logic [DATA_W-1:0] rdata_q, eng_q, rd_word;
    logic              rvalid_q, eng_vld_q, eng_rd;
    logic [ADDR_W-1:0] raddr;

    chk_state_e        state_q, state_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d, acc_add;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              ok_q, ok_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A load in the same cycle as rd_req reads at the freshly loaded value.
    always_comb begin
        seg_eff = seg_load ? seg : seg_q;
        off_eff = off_load ? off : off_q;
        off_d   = rd_req ? off_eff + OFF_W'(1) : off_eff;
    end

    // DDC reads win the single read port; the engine only reads when rd_req is low.
    always_comb begin
        eng_rd  = (state_q == StRun) && !rd_req;
        raddr   = rd_req ? {seg_eff, off_eff} : {blk_q, cnt_q};
        rd_word = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q     <= '0;
            off_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            eng_q     <= '0;
            eng_vld_q <= 1'b0;
        end else begin
            seg_q     <= seg_eff;
            off_q     <= off_d;
            rvalid_q  <= rd_req;
            eng_vld_q <= eng_rd;
            if (rd_req) begin
                rdata_q <= rd_word;
            end
            if (eng_rd) begin
                eng_q <= rd_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            blk_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        ok_d    = ok_q;
        acc_add = acc_q + (eng_vld_q ? eng_q : '0);
        unique case (state_q)
            StIdle: begin
                if (chk_start) begin
                    blk_d   = chk_block;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_add;
                if (eng_rd) begin
                    if (cnt_q == CNT_W'(BLOCK_BYTES - 1)) begin
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                // Result registers are loaded here so they are visible during StDone.
                acc_d   = acc_add;
                sum_d   = acc_add;
                ok_d    = (acc_add == '0);
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign chk_busy = (state_q == StRun) || (state_q == StDrain);
    assign chk_done = (state_q == StDone);
    assign chk_sum  = sum_q;
    assign chk_ok   = ok_q;

endmodule

// File: tb/tb_edid_store.sv
// Self-checking bench for edid_store: table vectors, directed checksum/collision/abort
// sequences and a randomized read/write phase against a byte-array reference model.
module tb_edid_store;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we = 1'b0;
    logic [14:0] waddr = '0;
    logic [7:0]  wdata = '0;
    logic        seg_load = 1'b0;
    logic [6:0]  seg = '0;
    logic        off_load = 1'b0;
    logic [7:0]  off = '0;
    logic        rd_req = 1'b0;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        chk_start = 1'b0;
    logic [7:0]  chk_block = '0;
    logic        chk_busy;
    logic        chk_done;
    logic [7:0]  chk_sum;
    logic        chk_ok;

    edid_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .seg_load  (seg_load),
        .seg       (seg),
        .off_load  (off_load),
        .off       (off),
        .rd_req    (rd_req),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .chk_start (chk_start),
        .chk_block (chk_block),
        .chk_busy  (chk_busy),
        .chk_done  (chk_done),
        .chk_sum   (chk_sum),
        .chk_ok    (chk_ok)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_mem [1024];
    int         m_seg = 0;
    int         m_off = 0;
    logic [7:0] exp_rd = '0;

    typedef struct {
        bit sl;
        int s;
        bit ol;
        int o;
        int addr;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model tracks pointers and expected read data.
    task automatic step(input bit r, input bit sl, input int s, input bit ol, input int o,
                        input bit w, input int wa, input int wd);
        int se;
        int oe;
        se = sl ? s : m_seg;
        oe = ol ? o : m_off;
        if (r) begin
            exp_rd = m_mem[(se << 8) | oe];
            oe = (oe + 1) % 256;
        end
        m_seg = se;
        m_off = oe;
        seg_load = sl;
        seg      = 7'(s);
        off_load = ol;
        off      = 8'(o);
        rd_req   = r;
        we       = w;
        waddr    = 15'(wa);
        wdata    = 8'(wd);
        @(posedge clk);
        #1;
        seg_load = 1'b0;
        off_load = 1'b0;
        rd_req   = 1'b0;
        we       = 1'b0;
        if (w) m_mem[wa] = 8'(wd);
    endtask

    task automatic wr(input int a, input int d);
        step(0, 0, 0, 0, 0, 1, a, d);
    endtask

    function automatic int blk_sum(input int b);
        int s = 0;
        for (int i = 0; i < 128; i++) s += m_mem[b * 128 + i];
        return s % 256;
    endfunction

    // Returns the cycle index (chk_start cycle = 0) at which chk_done is seen.
    task automatic run_chk(input int blk, input int stall_at, input int stall_len,
                           output int lat);
        chk_block = 8'(blk);
        chk_start = 1'b1;
        @(posedge clk);
        #1;
        chk_start = 1'b0;
        lat = 1;
        check("chk_busy_start", 32'(chk_busy), 1);
        while (chk_done !== 1'b1 && lat < 400) begin
            if (lat == stall_at) begin
                for (int i = 0; i < stall_len; i++) begin
                    step(1, i == 0, 2, i == 0, 'h40, 0, 0, 0);
                    lat++;
                    check("stall_rdata", 32'(rdata), 32'(exp_rd));
                    check("stall_rvalid", 32'(rvalid), 1);
                end
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
    endtask

    task automatic chk_result(input string tag, input int blk, input int exp_lat,
                              input int lat);
        int s;
        s = blk_sum(blk);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_sum"}, 32'(chk_sum), 32'(s));
        check({tag, "_ok"}, 32'(chk_ok), 32'(s == 0));
        check({tag, "_busy_at_done"}, 32'(chk_busy), 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(chk_done), 0);
        check({tag, "_sum_hold"}, 32'(chk_sum), 32'(s));
    endtask

    initial begin
        int lat;
        int seen;
        int guard;
        logic [7:0] old;

        tbl[0] = '{1, 2, 1, 'hFF, 'h2FF};
        tbl[1] = '{0, 0, 0, 0,    'h200};
        tbl[2] = '{0, 0, 0, 0,    'h201};
        tbl[3] = '{0, 0, 1, 'h10, 'h210};
        tbl[4] = '{1, 0, 0, 0,    'h011};
        tbl[5] = '{1, 3, 1, 'h7F, 'h37F};
        tbl[6] = '{0, 0, 0, 0,    'h380};
        tbl[7] = '{1, 1, 0, 0,    'h181};

        #1 rst_n = 1'b0;
        #11;
        check("rst_rdata", 32'(rdata), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_busy", 32'(chk_busy), 0);
        check("rst_done", 32'(chk_done), 0);
        check("rst_sum", 32'(chk_sum), 0);
        check("rst_ok", 32'(chk_ok), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int a = 0; a < 1024; a++) wr(a, (a * 37 + (a >> 8) * 101 + 11) % 256);

        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_ptr_read", 32'(rdata), 32'(exp_rd));

        for (int i = 0; i < 8; i++) begin
            step(1, tbl[i].sl, tbl[i].s, tbl[i].ol, tbl[i].o, 0, 0, 0);
            check($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 1);
            check($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(m_mem[tbl[i].addr]));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_rvalid", 32'(rvalid), 0);
        check("idle_rdata_hold", 32'(rdata), 32'(exp_rd));

        for (int i = 0; i < 128; i++) wr(128 + i, (i == 127) ? 'h81 : 'h01);
        run_chk(1, 0, 0, lat);
        chk_result("valid", 1, 130, lat);
        check("valid_sum_zero", 32'(chk_sum), 0);

        wr(255, 'h80);
        run_chk(1, 0, 0, lat);
        chk_result("invalid", 1, 130, lat);
        check("invalid_sum_ff", 32'(chk_sum), 'hFF);

        run_chk(1, 50, 10, lat);
        chk_result("stalled", 1, 140, lat);

        wr('h10, 'hAA);
        old = m_mem['h10];
        step(1, 1, 0, 1, 'h10, 1, 'h10, 'h55);
        check("collide_old", 32'(rdata), 32'(old));
        step(1, 1, 0, 1, 'h10, 0, 0, 0);
        check("collide_new", 32'(rdata), 32'(exp_rd));

        // Random DDC/write traffic with a checksum running underneath.
        chk_block = 8'd3;
        chk_start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bit r;
            r = 1'($urandom % 2);
            step(r, ($urandom % 4) == 0, $urandom % 4, ($urandom % 4) == 0, $urandom % 256,
                 ($urandom % 3) == 0, $urandom % 1024, $urandom % 256);
            chk_start = 1'b0;
            check("rand_rvalid", 32'(rvalid), 32'(r));
            check("rand_rdata", 32'(rdata), 32'(exp_rd));
        end
        guard = 0;
        while (chk_busy === 1'b1 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("rand_chk_finished", 32'(chk_busy), 0);

        chk_block = 8'd1;
        chk_start = 1'b1;
        @(posedge clk);
        #1;
        chk_start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_rdata", 32'(rdata), 0);
        check("abort_rvalid", 32'(rvalid), 0);
        check("abort_busy", 32'(chk_busy), 0);
        check("abort_done", 32'(chk_done), 0);
        check("abort_sum", 32'(chk_sum), 0);
        check("abort_ok", 32'(chk_ok), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_seg = 0;
        m_off = 0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (chk_done === 1'b1 || chk_busy === 1'b1) seen++;
        end
        check("abort_no_done", 32'(seen), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("abort_ptr_read", 32'(rdata), 32'(exp_rd));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
